// File: rtl/score_pkg.sv
// Shared types and constants for the Pong score path.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    PLAY      = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

endpackage

// File: rtl/score_ctrl_tick_gen.sv
// Modulo-N cycle counter with synchronous clear; tick is high on the last count of each period.
module tick_gen #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/score_ctrl.sv
// Pong match sequencer: scores, serve countdown, win detection and score-display blinking.
module score_ctrl
  import score_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int SEC_CYCLES   = 65_000_000,
  parameter int COUNT_SECS   = 3,
  parameter int BLINK_CYCLES = 16_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       point_l,
  input  logic       point_r,
  input  logic       new_game,
  output logic [7:0] points,
  output logic       serve_en,
  output logic [1:0] winner
);

  localparam int SW = $clog2(COUNT_SECS + 1);
  localparam logic [SW-1:0] SECS_INIT = SW'(COUNT_SECS);
  localparam logic [3:0]    WIN_BCD   = 4'(WIN_SCORE);

  state_t          state, state_n;
  logic [3:0]      score_l, score_l_n, score_r, score_r_n;
  logic [1:0]      winner_n;
  logic [SW-1:0]   secs_left, secs_left_n;
  logic            blink_on, blink_on_n;
  logic            sec_tick, blink_tick;
  logic            sec_clr, blink_clr, blink_state;
  logic [7:0]      points_n;

  function automatic logic [7:0] fmt_points(input state_t st, input logic [3:0] l,
                                            input logic [3:0] r, input logic [1:0] w,
                                            input logic on);
    logic [7:0] p;
    p = {l, r};
    case (st)
      IDLE:      p = 8'h00;
      COUNTDOWN: p = on ? {l, r} : {DIGIT_BLANK, DIGIT_BLANK};
      GAME_OVER: begin
        if (!on && w == WIN_LEFT)  p = {DIGIT_BLANK, r};
        if (!on && w == WIN_RIGHT) p = {l, DIGIT_BLANK};
      end
      default:   p = {l, r};
    endcase
    return p;
  endfunction

  assign blink_state = (state == COUNTDOWN) || (state == GAME_OVER);
  assign sec_clr     = !rst || new_game || (state != COUNTDOWN);
  assign blink_clr   = !rst || new_game || !blink_state;

  tick_gen #(.N(SEC_CYCLES)) u_sec (
    .clk  (clk),
    .clr  (sec_clr),
    .en   (state == COUNTDOWN),
    .tick (sec_tick)
  );

  tick_gen #(.N(BLINK_CYCLES)) u_blink (
    .clk  (clk),
    .clr  (blink_clr),
    .en   (blink_state),
    .tick (blink_tick)
  );

  always_comb begin
    state_n     = state;
    score_l_n   = score_l;
    score_r_n   = score_r;
    winner_n    = winner;
    secs_left_n = secs_left;
    if (new_game) begin
      state_n     = COUNTDOWN;
      score_l_n   = 4'd0;
      score_r_n   = 4'd0;
      winner_n    = WIN_NONE;
      secs_left_n = SECS_INIT;
    end else begin
      case (state)
        COUNTDOWN: begin
          if (sec_tick) begin
            secs_left_n = secs_left - SW'(1);
            if (secs_left == SW'(1)) state_n = PLAY;
          end
        end
        PLAY: begin
          // Left wins a simultaneous goal; right's pulse is dropped.
          if (point_l || point_r) begin
            if (point_l) score_l_n = score_l + 4'd1;
            else         score_r_n = score_r + 4'd1;
            if (score_l_n == WIN_BCD || score_r_n == WIN_BCD) begin
              state_n  = GAME_OVER;
              winner_n = point_l ? WIN_LEFT : WIN_RIGHT;
            end else begin
              state_n     = COUNTDOWN;
              secs_left_n = SECS_INIT;
            end
          end
        end
        default: ;
      endcase
    end

    if (new_game || state_n != state || !(state_n == COUNTDOWN || state_n == GAME_OVER))
      blink_on_n = 1'b1;
    else if (blink_tick)
      blink_on_n = !blink_on;
    else
      blink_on_n = blink_on;

    points_n = fmt_points(state_n, score_l_n, score_r_n, winner_n, blink_on_n);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      winner    <= WIN_NONE;
      secs_left <= '0;
      blink_on  <= 1'b1;
      points    <= 8'h00;
      serve_en  <= 1'b0;
    end else begin
      state     <= state_n;
      score_l   <= score_l_n;
      score_r   <= score_r_n;
      winner    <= winner_n;
      secs_left <= secs_left_n;
      blink_on  <= blink_on_n;
      points    <= points_n;
      serve_en  <= (state_n == PLAY);
    end
  end

endmodule
